// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received words in a first-word-fall-through FIFO and tracks overflow, break and error status.
// Define UART_RX_CTRL_ERRCNT_EN to build the saturating receive-error counter; otherwise err_count is tied to 0.
module uart_rx_ctrl #(
  parameter int DataBits = 8,
  parameter int Depth    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [DataBits-1:0]        rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_break,
  input  logic                       rx_error,
  output logic [DataBits-1:0]        m_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  input  logic                       clr_status,
  output logic                       overflow,
  output logic                       break_seen,
  output logic [7:0]                 err_count,
  output logic [$clog2(Depth):0]     level,
  output logic [1:0]                 fsm_state
);

  localparam int PW = $clog2(Depth);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_ACTIVE  = 2'd0,
    S_DISCARD = 2'd1,
    S_BREAK   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DataBits-1:0] r_mem [Depth];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;
  logic [LW-1:0]       w_level_nxt;
  logic                r_overflow;
  logic                r_break_seen;

  logic w_vld;
  logic w_brk;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_ovf_evt;
  logic w_break_evt;

  // Output side: m_valid means m_data holds the oldest word; a pop happens on
  // any edge where m_valid && m_ready, independent of enable and FSM state.
  assign w_pop  = (r_level != '0) && m_ready;
  assign w_full = (r_level == LW'(Depth));
  assign w_vld  = enable && rx_valid;
  assign w_brk  = enable && rx_break;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_ACTIVE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACTIVE: begin
        if (w_brk)          w_state_nxt = S_BREAK;
        else if (w_ovf_evt) w_state_nxt = S_DISCARD;
      end
      S_DISCARD: begin
        if (w_brk)                              w_state_nxt = S_BREAK;
        else if (enable && w_level_nxt == '0)   w_state_nxt = S_ACTIVE;
      end
      S_BREAK: begin
        if (w_vld) w_state_nxt = w_ovf_evt ? S_DISCARD : S_ACTIVE;
      end
      default: w_state_nxt = S_ACTIVE;
    endcase
  end

  // A word at a full buffer still fits if the consumer pops in the same cycle.
  always_comb begin
    w_push      = 1'b0;
    w_ovf_evt   = 1'b0;
    w_break_evt = 1'b0;
    case (r_state)
      S_ACTIVE: begin
        w_break_evt = w_brk;
        if (w_vld && !w_brk) begin
          if (!w_full || w_pop) w_push    = 1'b1;
          else                  w_ovf_evt = 1'b1;
        end
      end
      S_DISCARD: begin
        w_break_evt = w_brk;
      end
      S_BREAK: begin
        if (w_vld) begin
          if (!w_full || w_pop) w_push    = 1'b1;
          else                  w_ovf_evt = 1'b1;
        end
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_level <= w_level_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  // A setting event in the same cycle as clr_status wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow   <= 1'b0;
      r_break_seen <= 1'b0;
    end else begin
      r_overflow   <= w_ovf_evt   || (r_overflow   && !clr_status);
      r_break_seen <= w_break_evt || (r_break_seen && !clr_status);
    end
  end

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic       w_err_evt;
  logic [7:0] r_err_cnt;

  assign w_err_evt = enable && rx_error && (r_state != S_BREAK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_evt) begin
      if (clr_status)              r_err_cnt <= 8'd1;
      else if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end else if (clr_status) begin
      r_err_cnt <= 8'd0;
    end
  end

  assign err_count = r_err_cnt;
`else
  logic w_unused_err;
  assign w_unused_err = rx_error;
  assign err_count    = 8'd0;
`endif

  assign m_data     = r_mem[r_rd_ptr];
  assign m_valid    = (r_level != '0);
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign break_seen = r_break_seen;
  assign fsm_state  = r_state;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (Depth=4, DataBits=8).
module tb_uart_rx_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_break;
  logic       rx_error;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       clr_status;
  logic       overflow;
  logic       break_seen;
  logic [7:0] err_count;
  logic [2:0] level;
  logic [1:0] fsm_state;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];
  logic [7:0] exp_word;
  logic [7:0] exp_err;

  uart_rx_ctrl #(.DataBits(8), .Depth(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_break   (rx_break),
    .rx_error   (rx_error),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .clr_status (clr_status),
    .overflow   (overflow),
    .break_seen (break_seen),
    .err_count  (err_count),
    .level      (level),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply one cycle of inputs at negedge, release pulses 1ns after posedge
  task automatic step(input logic v, input logic [7:0] d, input logic b,
                      input logic e, input logic rdy, input logic clr);
    @(negedge clk);
    rx_valid = v; rx_data = d; rx_break = b; rx_error = e;
    m_ready = rdy; clr_status = clr;
    @(posedge clk);
    #1;
    rx_valid = 1'b0; rx_break = 1'b0; rx_error = 1'b0;
    m_ready = 1'b0; clr_status = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    while (exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== exp_word) begin
        n_fail++;
        $display("FAIL %s_drain got valid=%b data=%h exp valid=1 data=%h", tag, m_valid, m_data, exp_word);
      end
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_empty got level=%0d valid=%b exp level=0 valid=0", tag, level, m_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1;
    rx_valid = 1'b0; rx_break = 1'b0; rx_error = 1'b0; rx_data = 8'h00;
    m_ready = 1'b0; clr_status = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0 || overflow !== 1'b0 || break_seen !== 1'b0
        || err_count !== 8'd0 || fsm_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state got level=%0d valid=%b ovf=%b brk=%b err=%0d st=%0d exp all 0",
               level, m_valid, overflow, break_seen, err_count, fsm_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd1 || m_valid !== 1'b1 || m_data !== 8'h11) begin
      n_fail++;
      $display("FAIL fill_latency got level=%0d valid=%b data=%h exp 1 1 11", level, m_valid, m_data);
    end
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd4 || m_valid !== 1'b1 || m_data !== 8'h11 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full got level=%0d valid=%b data=%h ovf=%b exp 4 1 11 0", level, m_valid, m_data, overflow);
    end
  endtask

  task automatic test_overflow;
    test_fill();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1 || fsm_state !== 2'd1 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_set got ovf=%b st=%0d level=%0d exp 1 1 4", overflow, fsm_state, level);
    end
    step(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd4 || fsm_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ovf_discard got level=%0d st=%0d exp 4 1", level, fsm_state);
    end
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    drain_check("ovf");
    n_checks++;
    if (fsm_state !== 2'd0) begin
      n_fail++;
      $display("FAIL ovf_return got st=%0d exp 0", fsm_state);
    end
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd1 || m_data !== 8'h77) begin
      n_fail++;
      $display("FAIL ovf_accept got level=%0d data=%h exp 1 77", level, m_data);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (overflow !== 1'b0 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL ovf_clear got ovf=%b level=%0d exp 0 0", overflow, level);
    end
  endtask

  task automatic test_full_pop;
    test_fill();
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (level !== 3'd4 || overflow !== 1'b0 || m_data !== 8'h22 || fsm_state !== 2'd0) begin
      n_fail++;
      $display("FAIL fullpop got level=%0d ovf=%b data=%h st=%0d exp 4 0 22 0", level, overflow, m_data, fsm_state);
    end
    exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    drain_check("fullpop");
  endtask

  task automatic test_clr_coincide;
    test_fill();
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (overflow !== 1'b1 || level !== 3'd4) begin
      n_fail++;
      $display("FAIL clr_ovf_win got ovf=%b level=%0d exp 1 4", overflow, level);
    end
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    drain_check("clrwin");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_break;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (break_seen !== 1'b1 || fsm_state !== 2'd2 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL brk_set got brk=%b st=%0d level=%0d exp 1 2 0", break_seen, fsm_state, level);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (err_count !== 8'd0 || fsm_state !== 2'd2) begin
      n_fail++;
      $display("FAIL brk_err_ignored got err=%0d st=%0d exp 0 2", err_count, fsm_state);
    end
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (fsm_state !== 2'd0 || level !== 3'd1 || m_data !== 8'hA5 || break_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL brk_word got st=%0d level=%0d data=%h brk=%b exp 0 1 a5 1", fsm_state, level, m_data, break_seen);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (break_seen !== 1'b0 || level !== 3'd1 || m_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL brk_clear got brk=%b level=%0d data=%h exp 0 1 a5", break_seen, level, m_data);
    end
    exp_q.push_back(8'hA5);
    drain_check("brk");
  endtask

  task automatic test_errcnt;
`ifdef UART_RX_CTRL_ERRCNT_EN
    exp_err = 8'd10;
`else
    exp_err = 8'd0;
`endif
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (err_count !== exp_err) begin
      n_fail++;
      $display("FAIL err_count10 got %0d exp %0d", err_count, exp_err);
    end
    for (int i = 10; i < 300; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef UART_RX_CTRL_ERRCNT_EN
    exp_err = 8'd255;
`else
    exp_err = 8'd0;
`endif
    n_checks++;
    if (err_count !== exp_err) begin
      n_fail++;
      $display("FAIL err_saturate got %0d exp %0d", err_count, exp_err);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef UART_RX_CTRL_ERRCNT_EN
    exp_err = 8'd1;
`else
    exp_err = 8'd0;
`endif
    n_checks++;
    if (err_count !== exp_err) begin
      n_fail++;
      $display("FAIL err_clr_win got %0d exp %0d", err_count, exp_err);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL err_clear got %0d exp 0", err_count);
    end
  endtask

  task automatic test_enable;
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd1 || break_seen !== 1'b0 || err_count !== 8'd0 || fsm_state !== 2'd0) begin
      n_fail++;
      $display("FAIL enable_off got level=%0d brk=%b err=%0d st=%0d exp 1 0 0 0", level, break_seen, err_count, fsm_state);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_off_pop got level=%0d valid=%b exp 0 0", level, m_valid);
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd3 || break_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre got level=%0d brk=%b exp 3 1", level, break_seen);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0 || break_seen !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_during got level=%0d valid=%b brk=%b ovf=%b exp 0 0 0 0", level, m_valid, break_seen, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (level !== 3'd0 || m_valid !== 1'b0 || fsm_state !== 2'd0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL rstmid_after got level=%0d valid=%b st=%0d err=%0d exp 0 0 0 0", level, m_valid, fsm_state, err_count);
    end
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (level !== 3'd1 || m_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL rstmid_first got level=%0d data=%h exp 1 5a", level, m_data);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_overflow();
    test_full_pop();
    test_clr_coincide();
    test_break();
    test_errcnt();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
